// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer followed by a four-state
// stability FSM. A level change is accepted only after Wait consecutive
// stable synchronized samples; each accepted press emits one-cycle pulse.
module button_debouncer #(
  parameter int Wait = 40000,
  parameter int Size = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic button_pressed,
  output logic button_level
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Terminal count of the stability counter; the counter never goes past it.
  localparam logic [Size-1:0] LAST = Size'(Wait - 1);

  logic            sync1;
  logic            sync2;
  state_t          state;
  state_t          state_next;
  logic [Size-1:0] count;
  logic [Size-1:0] count_next;
  logic            pressed_next;
  logic            level_next;

  // Two-flop synchronizer; only sync2 is seen by the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= RELEASED;
      count          <= '0;
      button_pressed <= 1'b0;
      button_level   <= 1'b0;
    end else begin
      state          <= state_next;
      count          <= count_next;
      button_pressed <= pressed_next;
      button_level   <= level_next;
    end
  end

  // Next-state, counter and output decode. The counter is cleared on every
  // state entry and only advances while waiting for stability.
  always_comb begin
    state_next   = state;
    count_next   = '0;
    pressed_next = 1'b0;
    case (state)
      RELEASED: begin
        if (sync2) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!sync2) begin
          state_next = RELEASED;
        end else if (count == LAST) begin
          state_next   = PRESSED;
          pressed_next = 1'b1;
        end else begin
          count_next = count + Size'(1);
        end
      end
      PRESSED: begin
        if (!sync2) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (sync2) begin
          state_next = PRESSED;
        end else if (count == LAST) begin
          state_next = RELEASED;
        end else begin
          count_next = count + Size'(1);
        end
      end
      default: begin
        state_next = RELEASED;
      end
    endcase
    // Level follows the state being entered so it changes on the same edge
    // as the accepting transition.
    level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with Wait=4, Size=3.
// Press/release acceptance lands 6 edges after the first sampling edge.
module tb_button_debouncer;

  logic clock;
  logic reset;
  logic button;
  logic button_pressed;
  logic button_level;

  int n_checks;
  int n_pass;
  int pulses;
  int wide;
  logic prev_pressed;
  int snap;

  button_debouncer #(.Wait(4), .Size(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .button         (button),
    .button_pressed (button_pressed),
    .button_level   (button_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counter and pulse-width monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (button_pressed) pulses = pulses + 1;
    if (button_pressed && prev_pressed) wide = wide + 1;
    prev_pressed = button_pressed;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n posedges, leaving the bench 1 time unit after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    pulses = 0;
    wide = 0;
    prev_pressed = 1'b0;
    reset = 1'b1;
    button = 1'b1;

    // Reset clears outputs even with the button held.
    tick(3);
    check("reset_pressed", 32'(button_pressed), 0);
    check("reset_level", 32'(button_level), 0);
    button = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(4);
    check("idle_level", 32'(button_level), 0);

    // Clean press: pulse exactly after the 7th edge counted from the first sample.
    snap = pulses;
    button = 1'b1;
    tick(6);
    check("press_early_pulse", 32'(button_pressed), 0);
    check("press_early_level", 32'(button_level), 0);
    tick(1);
    check("press_pulse", 32'(button_pressed), 1);
    check("press_level", 32'(button_level), 1);
    tick(1);
    check("press_pulse_end", 32'(button_pressed), 0);
    check("press_level_hold", 32'(button_level), 1);

    // Held for 100 edges in total: still one pulse.
    tick(92);
    check("held_100_pulses", 32'(pulses - snap), 1);

    // Two-edge low glitch while pressed is absorbed.
    snap = pulses;
    button = 1'b0;
    tick(2);
    button = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("glitch_level", 32'(button_level), 1);
      tick(1);
    end
    check("glitch_no_pulse", 32'(pulses - snap), 0);

    // Release: level falls after the 7th edge counted from the first low sample.
    button = 1'b0;
    tick(6);
    check("release_level_early", 32'(button_level), 1);
    tick(1);
    check("release_level", 32'(button_level), 0);
    tick(3);

    // Bounce: 3 high, 2 low, then held high.
    snap = pulses;
    button = 1'b1;
    tick(3);
    button = 1'b0;
    tick(2);
    button = 1'b1;
    tick(6);
    check("bounce_no_early_pulse", 32'(pulses - snap), 0);
    check("bounce_level_early", 32'(button_level), 0);
    tick(1);
    check("bounce_pulse", 32'(button_pressed), 1);
    tick(1);
    check("bounce_pulse_end", 32'(button_pressed), 0);
    check("bounce_pulse_count", 32'(pulses - snap), 1);
    button = 1'b0;
    tick(10);
    check("bounce_release_level", 32'(button_level), 0);

    // Reset mid-PressWait with the counter at 2, then a held button.
    snap = pulses;
    button = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(1);
    check("midwait_reset_pressed", 32'(button_pressed), 0);
    check("midwait_reset_level", 32'(button_level), 0);
    reset = 1'b0;
    tick(6);
    check("after_reset_early", 32'(button_pressed), 0);
    tick(1);
    check("after_reset_pulse", 32'(button_pressed), 1);
    check("after_reset_level", 32'(button_level), 1);
    tick(1);
    check("after_reset_count", 32'(pulses - snap), 1);
    button = 1'b0;
    tick(12);

    // Reset on the very edge that would accept the press.
    snap = pulses;
    button = 1'b1;
    tick(6);
    reset = 1'b1;
    tick(1);
    check("same_edge_reset_pressed", 32'(button_pressed), 0);
    check("same_edge_reset_level", 32'(button_level), 0);
    button = 1'b0;
    reset = 1'b0;
    tick(3);
    check("same_edge_no_pulse", 32'(pulses - snap), 0);
    tick(5);

    // Three clean press/release cycles.
    snap = pulses;
    for (int c = 0; c < 3; c++) begin
      button = 1'b1;
      tick(20);
      check("cycle_level_high", 32'(button_level), 1);
      button = 1'b0;
      tick(20);
      check("cycle_level_low", 32'(button_level), 0);
    end
    check("three_cycle_pulses", 32'(pulses - snap), 3);
    check("pulse_width_one", 32'(wide), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Wait, 40000, number of consecutive stable synchronized samples required to accept a level change; legal range 1 to 2**Size-1.
REQ-002 Size, 16, width in bits of the stability counter.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 button  input  1  raw asynchronous push-button level, 1 = pressed.
REQ-006 button_pressed  output  1  registered, one-cycle pulse per accepted press; the downstream push-button device ORs it into its sticky status.
REQ-007 button_level  output  1  registered debounced level, 1 = accepted pressed.

Function
REQ-008 button SHALL pass through a two-flop synchronizer (sync1, sync2); only sync2 SHALL drive the FSM.
REQ-009 The FSM SHALL have four states: Released, PressWait, Pressed and ReleaseWait.
REQ-010 The stability counter SHALL be Size bits wide, SHALL load 0 on every state entry, and SHALL increment by 1 per cycle only in PressWait and ReleaseWait.
REQ-011 Released: sync2=1 -> PressWait with counter 0; otherwise remain in Released.
REQ-012 PressWait: sync2=0 -> Released (bounce rejected, no pulse); else counter=Wait-1 -> Pressed; else counter+1.
REQ-013 Pressed: sync2=0 -> ReleaseWait with counter 0; otherwise remain in Pressed.
REQ-014 ReleaseWait: sync2=1 -> Pressed (bounce rejected, no new pulse); else counter=Wait-1 -> Released; else counter+1.
REQ-015 button_pressed SHALL be 1 exactly in the cycle after the PressWait->Pressed transition edge, and 0 in all other cycles.
REQ-016 ReleaseWait->Pressed SHALL NOT generate button_pressed.
REQ-017 button_level SHALL be 1 while the state is Pressed or ReleaseWait, and 0 otherwise; it SHALL be registered with no combinational path from button.
REQ-018 Latency: if the first posedge sampling button=1 is edge k and button stays high, button_pressed SHALL be high after edge k+Wait+2 and low after edge k+Wait+3.
REQ-019 Release latency: button_level SHALL fall after edge k+Wait+2, where edge k is the first edge sampling button=0.
REQ-020 Held button: a continuously held button SHALL produce exactly one pulse, however long the hold.
REQ-021 Counter wrap: the counter SHALL never exceed Wait-1, and SHALL therefore never wrap.
REQ-022 An unreachable state encoding SHALL go to Released on the next edge, with both outputs 0 and the counter at 0.

Reset
REQ-023 While reset=1 at a posedge, the following SHALL be cleared: sync1, sync2, the state (to Released), the counter (to 0), button_pressed (to 0) and button_level (to 0).
REQ-024 Reset SHALL override every transition, including a reset asserted mid-PressWait or in the same cycle as the pulse; no pulse SHALL appear in the cycle after reset.
REQ-025 After reset is released, a button already held high SHALL be treated as a new press: one pulse, with the REQ-018 latency measured from the first non-reset edge.

Verification (Wait=4, Size=3)
REQ-026 Hold button=1 from edge 10 -> button_pressed=1 only after edge 16; button_level=1 from edge 16 onward.
REQ-027 Bounce: button=1 for 3 edges, then 0 for 2, then 1 held -> no pulse from the first burst; exactly one pulse, 6 edges after the final rise.
REQ-028 From Pressed, a 2-edge low glitch -> button_level stays 1 and no second pulse occurs; release held low for 10 edges -> button_level=0, 6 edges after the fall.
REQ-029 reset=1 for 1 edge while in PressWait (counter=2) -> both outputs 0, state Released; a held button yields one pulse 6 edges after reset drops.
REQ-030 Hold button=1 for 100 edges -> exactly one pulse is counted.
REQ-031 Three clean press/release cycles, each 20 edges high and 20 edges low -> exactly three pulses, each exactly one cycle wide.
